// File: rtl/smsdac_seq.sv
// rtl/smsdac_seq.sv - update-rate sequencer feeding a mismatch-shaping DAC core
// Sources: buffered stream, ramp, triangle or mute code, applied once per divider tick.
module smsdac_seq #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] div,
  input  logic [7:0]       code_in,
  input  logic             code_valid,
  output logic             code_ready,
  output logic [7:0]       dac_code,
  output logic             dac_stb,
  output logic             underrun,
  output logic             running
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam logic [1:0] M_STREAM = 2'b00;
  localparam logic [1:0] M_RAMP   = 2'b01;
  localparam logic [1:0] M_TRI    = 2'b10;
  localparam logic [1:0] M_MUTE   = 2'b11;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [7:0]       code_q, code_d;
  logic             stb_q, stb_d;
  logic             full_q, full_d;
  logic [7:0]       buf_q, buf_d;
  logic             urun_q, urun_d;
  logic             dir_q, dir_d;
  logic             last_tri_q, last_tri_d;

  logic tick;
  logic stream_tick;
  logic accept;
  logic dir_eff;

  assign tick        = (state_q == S_RUN) && (cnt_q == div);
  assign stream_tick = tick && (mode == M_STREAM);
  // Only a STREAM tick frees the slot; other modes must not overwrite a held sample.
  assign code_ready  = !full_q || stream_tick;
  assign accept      = code_valid && code_ready;
  assign dir_eff     = last_tri_q ? dir_q : 1'b1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    code_d     = code_q;
    stb_d      = tick;
    full_d     = full_q;
    buf_d      = buf_q;
    urun_d     = urun_q;
    dir_d      = dir_q;
    last_tri_d = last_tri_q;

    case (state_q)
      S_IDLE:  if (en) state_d = S_RUN;
      S_RUN:   if (!en) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_q == S_RUN && en) begin
      cnt_d = tick ? '0 : cnt_q + DIV_W'(1);
    end

    if (state_q == S_IDLE) begin
      urun_d = 1'b0;
    end

    if (tick) begin
      last_tri_d = (mode == M_TRI);
      case (mode)
        M_STREAM: begin
          if (full_q) begin
            code_d = buf_q;
            full_d = 1'b0;
          end else begin
            urun_d = 1'b1;
          end
        end
        M_RAMP: code_d = code_q + 8'd1;
        M_TRI: begin
          if (dir_eff) begin
            if (code_q == 8'hFF) begin
              code_d = 8'hFE;
              dir_d  = 1'b0;
            end else begin
              code_d = code_q + 8'd1;
              dir_d  = 1'b1;
            end
          end else begin
            if (code_q == 8'h00) begin
              code_d = 8'h01;
              dir_d  = 1'b1;
            end else begin
              code_d = code_q - 8'd1;
              dir_d  = 1'b0;
            end
          end
        end
        M_MUTE:  code_d = 8'h80;
        default: code_d = code_q;
      endcase
    end

    if (accept) begin
      buf_d  = code_in;
      full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      code_q     <= 8'h80;
      stb_q      <= 1'b0;
      full_q     <= 1'b0;
      buf_q      <= 8'h00;
      urun_q     <= 1'b0;
      dir_q      <= 1'b1;
      last_tri_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      code_q     <= code_d;
      stb_q      <= stb_d;
      full_q     <= full_d;
      buf_q      <= buf_d;
      urun_q     <= urun_d;
      dir_q      <= dir_d;
      last_tri_q <= last_tri_d;
    end
  end

  assign dac_code = code_q;
  assign dac_stb  = stb_q;
  assign underrun = urun_q;
  assign running  = (state_q == S_RUN);

endmodule

// File: tb/tb_smsdac_seq.sv
// tb/tb_smsdac_seq.sv - self-checking bench for smsdac_seq
// Directed steps followed by random traffic against a behavioural model.
module tb_smsdac_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] div = 8'd0;
  logic [7:0] code_in = 8'd0;
  logic       code_valid = 1'b0;
  logic       code_ready;
  logic [7:0] dac_code;
  logic       dac_stb;
  logic       underrun;
  logic       running;

  int ncmp = 0;
  int nerr = 0;

  // behavioural model state
  bit m_run;
  int m_ph;
  int m_q[$];
  int m_code;
  bit m_stb;
  bit m_urun;
  bit m_up;
  int m_prev;

  smsdac_seq #(.DIV_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .div(div),
    .code_in(code_in), .code_valid(code_valid), .code_ready(code_ready),
    .dac_code(dac_code), .dac_stb(dac_stb), .underrun(underrun), .running(running)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_ph = 0; m_q.delete(); m_code = 128;
    m_stb = 0; m_urun = 0; m_up = 1; m_prev = -1;
  endtask

  function automatic bit model_tick();
    return m_run && (m_ph == int'(div));
  endfunction

  function automatic bit model_ready();
    return (m_q.size() == 0) || (model_tick() && mode == 2'b00);
  endfunction

  task automatic model_edge();
    bit tk, rdy;
    if (rst) begin
      model_reset();
      return;
    end
    tk  = model_tick();
    rdy = model_ready();
    m_stb = tk;
    if (tk) begin
      case (int'(mode))
        0: if (m_q.size() > 0) m_code = m_q.pop_front(); else m_urun = 1;
        1: m_code = (m_code + 1) % 256;
        2: begin
          if (m_prev != 2) m_up = 1;
          if (m_up) begin
            if (m_code == 255) begin m_code = 254; m_up = 0; end else m_code = m_code + 1;
          end else begin
            if (m_code == 0) begin m_code = 1; m_up = 1; end else m_code = m_code - 1;
          end
        end
        default: m_code = 128;
      endcase
      m_prev = int'(mode);
    end
    if (code_valid && rdy) m_q.push_back(int'(code_in));
    if (!m_run) begin
      m_urun = 0;
      if (en) begin m_run = 1; m_ph = 0; end
    end else if (!en) begin
      m_run = 0; m_ph = 0;
    end else begin
      m_ph = tk ? 0 : (m_ph + 1) % 256;
    end
  endtask

  // One clock: check ready before the edge, advance model at the edge, check outputs after.
  task automatic cycle();
    #1;
    if (!rst) chk("code_ready", code_ready, model_ready());
    @(posedge clk);
    model_edge();
    #1;
    chk("dac_code", dac_code, m_code);
    chk("dac_stb", dac_stb, m_stb);
    chk("underrun", underrun, m_urun);
    chk("running", running, m_run);
  endtask

  task automatic wait_stb(input string tag, input int max, output int n);
    n = 0;
    do begin
      cycle();
      n++;
    end while (!dac_stb && n < max);
    chk({tag, "_stb_seen"}, dac_stb, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1; en = 0; code_valid = 0;
    cycle();
    rst = 0;
  endtask

  initial begin
    int n;
    model_reset();

    // reset state
    do_reset();
    chk("rst_code", dac_code, 8'h80);
    chk("rst_stb", dac_stb, 1'b0);
    chk("rst_underrun", underrun, 1'b0);
    chk("rst_running", running, 1'b0);
    chk("rst_ready", code_ready, 1'b1);

    // ramp at full rate with wrap
    en = 1; mode = 2'b01; div = 8'd0;
    cycle();
    cycle();
    chk("ramp_first", dac_code, 8'h81);
    repeat (130) cycle();
    chk("ramp_stb_const", dac_stb, 1'b1);

    // stream, two samples back to back
    do_reset();
    mode = 2'b00; div = 8'd3; en = 1; code_valid = 1; code_in = 8'h10;
    cycle();
    code_in = 8'h20;
    cycle();
    chk("s_ready_low", code_ready, 1'b0);
    wait_stb("s_first", 10, n);
    chk("s_first_lat", n, 3);
    chk("s_first_code", dac_code, 8'h10);
    code_valid = 0;
    wait_stb("s_second", 10, n);
    chk("s_second_lat", n, 4);
    chk("s_second_code", dac_code, 8'h20);

    // stream underrun, cleared by idle
    do_reset();
    mode = 2'b00; div = 8'd2; en = 1;
    cycle();
    wait_stb("u_first", 10, n);
    chk("u_first_lat", n, 3);
    chk("u_code", dac_code, 8'h80);
    chk("u_flag", underrun, 1'b1);
    wait_stb("u_second", 10, n);
    chk("u_period", n, 3);
    en = 0;
    cycle();
    cycle();
    chk("u_cleared", underrun, 1'b0);

    // triangle turnarounds
    do_reset();
    en = 1; mode = 2'b01; div = 8'd0;
    n = 0;
    do begin cycle(); n++; end while (dac_code != 8'hFD && n < 300);
    chk("t_reach_fd", dac_code, 8'hFD);
    mode = 2'b10;
    cycle(); chk("t_fe", dac_code, 8'hFE);
    cycle(); chk("t_ff", dac_code, 8'hFF);
    cycle(); chk("t_fe2", dac_code, 8'hFE);
    cycle(); chk("t_fd", dac_code, 8'hFD);
    n = 0;
    do begin cycle(); n++; end while (dac_code != 8'h02 && n < 300);
    chk("t_reach_02", dac_code, 8'h02);
    cycle(); chk("t_01", dac_code, 8'h01);
    cycle(); chk("t_00", dac_code, 8'h00);
    cycle(); chk("t_01b", dac_code, 8'h01);

    // consume and refill on the same tick; sample loaded while idle
    do_reset();
    mode = 2'b00; div = 8'd3; code_valid = 1; code_in = 8'hAA;
    cycle();
    code_in = 8'hBB; en = 1;
    cycle();
    wait_stb("r_first", 10, n);
    chk("r_old_out", dac_code, 8'hAA);
    chk("r_no_underrun", underrun, 1'b0);
    code_valid = 0;
    wait_stb("r_second", 10, n);
    chk("r_new_out", dac_code, 8'hBB);
    chk("r_no_underrun2", underrun, 1'b0);

    // reset mid-run discards the buffered sample
    do_reset();
    mode = 2'b00; div = 8'd5; en = 1; code_valid = 1; code_in = 8'h5A;
    cycle();
    code_valid = 0;
    cycle();
    cycle();
    chk("x_running", running, 1'b1);
    rst = 1;
    cycle();
    chk("x_code", dac_code, 8'h80);
    chk("x_running0", running, 1'b0);
    chk("x_stb", dac_stb, 1'b0);
    chk("x_ready", code_ready, 1'b1);
    rst = 0;
    wait_stb("x_after", 20, n);
    chk("x_discarded", underrun, 1'b1);

    // shrinking div below the count wraps the counter
    do_reset();
    mode = 2'b01; div = 8'd10; en = 1;
    cycle();
    repeat (5) cycle();
    div = 8'd2;
    wait_stb("d_wrap", 300, n);
    chk("d_wrap_lat", n, 254);

    // random traffic
    en = 1;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 49) == 0) en = ~en;
      if ($urandom_range(0, 29) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0)
        div = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 3));
      code_valid = ($urandom_range(0, 2) == 0);
      code_in = 8'($urandom);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
